// File: rtl/pwm_color_mixer_if.sv
// Button and LED/status bundle of the RGB colour mixer.
// The slave side is the mixer; the master side is whoever presses the buttons.
interface pwm_color_mixer_if;
  logic       next_i;
  logic       bright_i;
  logic       mode_i;
  logic [2:0] led_o;
  logic [2:0] color_o;
  logic [1:0] bright_o;
  logic       mode_o;

  modport master (
    output next_i, bright_i, mode_i,
    input  led_o, color_o, bright_o, mode_o
  );

  modport slave (
    input  next_i, bright_i, mode_i,
    output led_o, color_o, bright_o, mode_o
  );
endinterface

// File: rtl/pwm_color_mixer.sv
// RGB palette mixer with brightness steps, auto-cycle mode and glitch-free PWM.
// Shadow registers reload only at the end of a PWM period so pulses are never cut.
module pwm_color_mixer #(
  parameter int NUM_COLORS  = 8,
  parameter int PWM_W       = 8,
  parameter int HOLD_CYCLES = 12_000_000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic             clk,
  input  logic             rst,
  pwm_color_mixer_if.slave bus
);

  localparam int              HOLD_W     = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [2:0]      LAST_COLOR = 3'(NUM_COLORS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [2:0]      LED_INV    = (ACTIVE_LOW != 0) ? 3'b111 : 3'b000;

  typedef enum logic {
    MODE_STATIC = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_t;

  mode_t             mode_q, mode_d;
  logic [2:0]        color_q, color_d;
  logic [1:0]        bright_q, bright_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [2:0]        prev_q;

  logic [PWM_W-1:0]  cnt_q;
  logic [2:0]        act_rgb_q;
  logic [PWM_W-1:0]  act_duty_q;
  logic [2:0]        led_q;

  logic next_ev, bright_ev, mode_ev, enter_auto, hold_tc, advance;
  logic [2:0] lit;

  function automatic logic [2:0] palette(input logic [2:0] idx);
    case (idx)
      3'd1:    palette = 3'b100;
      3'd2:    palette = 3'b010;
      3'd3:    palette = 3'b001;
      3'd4:    palette = 3'b110;
      3'd5:    palette = 3'b011;
      3'd6:    palette = 3'b101;
      3'd7:    palette = 3'b111;
      default: palette = 3'b000;
    endcase
  endfunction

  assign next_ev    = bus.next_i   & ~prev_q[2];
  assign bright_ev  = bus.bright_i & ~prev_q[1];
  assign mode_ev    = bus.mode_i   & ~prev_q[0];
  assign enter_auto = mode_ev & (mode_q == MODE_STATIC);
  assign hold_tc    = (mode_q == MODE_AUTO) && (hold_q == HOLD_LAST);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    mode_d   = mode_q;
    color_d  = color_q;
    bright_d = bright_q;
    hold_d   = hold_q;
    advance  = 1'b0;

    if (mode_ev)
      mode_d = (mode_q == MODE_STATIC) ? MODE_AUTO : MODE_STATIC;
    if (bright_ev)
      bright_d = bright_q + 2'd1;

    // Expiry only counts while we stay in AUTO; a simultaneous next merges into one step.
    advance = next_ev | (hold_tc & (mode_d == MODE_AUTO));

    if (advance) begin
      if (mode_d == MODE_AUTO)
        color_d = (color_q >= LAST_COLOR) ? 3'd1 : color_q + 3'd1;
      else
        color_d = (color_q >= LAST_COLOR) ? 3'd0 : color_q + 3'd1;
    end else if (enter_auto && color_q == 3'd0) begin
      color_d = 3'd1;
    end

    if (mode_d == MODE_STATIC || enter_auto || next_ev || hold_tc)
      hold_d = '0;
    else
      hold_d = hold_q + HOLD_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= MODE_STATIC;
      color_q  <= 3'd0;
      bright_q <= 2'd3;
      hold_q   <= '0;
      prev_q   <= 3'b111;
    end else begin
      mode_q   <= mode_d;
      color_q  <= color_d;
      bright_q <= bright_d;
      hold_q   <= hold_d;
      prev_q   <= {bus.next_i, bus.bright_i, bus.mode_i};
    end
  end

  assign lit = act_rgb_q & {3{cnt_q <= act_duty_q}};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      act_rgb_q  <= 3'b000;
      act_duty_q <= '1;
      led_q      <= LED_INV;
    end else begin
      cnt_q <= cnt_q + PWM_W'(1);
      if (cnt_q == '1) begin
        act_rgb_q  <= palette(color_q);
        act_duty_q <= {bright_q, {(PWM_W-2){1'b1}}};
      end
      led_q <= lit ^ LED_INV;
    end
  end

  assign bus.led_o    = led_q;
  assign bus.color_o  = color_q;
  assign bus.bright_o = bright_q;
  assign bus.mode_o   = (mode_q == MODE_AUTO);

endmodule

// File: tb/tb_pwm_color_mixer.sv
// Directed bench for pwm_color_mixer: button vector table plus PWM and AUTO timing sequences.
// An 8-colour and a 5-colour instance share the same button stimulus.
module tb_pwm_color_mixer;

  logic clk = 1'b0;
  logic rst;
  logic next_r, bright_r, mode_r;

  int n_checks = 0;
  int n_fail   = 0;

  pwm_color_mixer_if bus8 ();
  pwm_color_mixer_if bus5 ();

  assign bus8.next_i   = next_r;
  assign bus8.bright_i = bright_r;
  assign bus8.mode_i   = mode_r;
  assign bus5.next_i   = next_r;
  assign bus5.bright_i = bright_r;
  assign bus5.mode_i   = mode_r;

  pwm_color_mixer #(.NUM_COLORS(8), .PWM_W(4), .HOLD_CYCLES(20), .ACTIVE_LOW(1))
    dut8 (.clk(clk), .rst(rst), .bus(bus8));
  pwm_color_mixer #(.NUM_COLORS(5), .PWM_W(4), .HOLD_CYCLES(20), .ACTIVE_LOW(1))
    dut5 (.clk(clk), .rst(rst), .bus(bus5));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] btn;     // {next, bright, mode}
    logic [2:0] color8;
    logic [2:0] color5;
    logic [1:0] bright;
    logic       mode;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [2:0] btn);
    {next_r, bright_r, mode_r} = btn;
    tick();
    {next_r, bright_r, mode_r} = 3'b000;
    tick();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  // Count lit (low) cycles of r, g and unlit cycles of b over 16 consecutive samples.
  task automatic measure(output int r_low, output int g_low, output int b_high);
    r_low = 0; g_low = 0; b_high = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus8.led_o[2] == 1'b0) r_low++;
      if (bus8.led_o[1] == 1'b0) g_low++;
      if (bus8.led_o[0] == 1'b1) b_high++;
    end
  endtask

  initial begin
    int r_low, g_low, b_high;
    int low0, low1;
    logic found, prev_r;
    logic [2:0] exp_seq[7];

    vecs[0]  = '{3'b100, 3'd1, 3'd1, 2'd3, 1'b0};
    vecs[1]  = '{3'b100, 3'd2, 3'd2, 2'd3, 1'b0};
    vecs[2]  = '{3'b100, 3'd3, 3'd3, 2'd3, 1'b0};
    vecs[3]  = '{3'b100, 3'd4, 3'd4, 2'd3, 1'b0};
    vecs[4]  = '{3'b100, 3'd5, 3'd0, 2'd3, 1'b0};
    vecs[5]  = '{3'b100, 3'd6, 3'd1, 2'd3, 1'b0};
    vecs[6]  = '{3'b100, 3'd7, 3'd2, 2'd3, 1'b0};
    vecs[7]  = '{3'b100, 3'd0, 3'd3, 2'd3, 1'b0};
    vecs[8]  = '{3'b010, 3'd0, 3'd3, 2'd0, 1'b0};
    vecs[9]  = '{3'b010, 3'd0, 3'd3, 2'd1, 1'b0};
    vecs[10] = '{3'b010, 3'd0, 3'd3, 2'd2, 1'b0};
    vecs[11] = '{3'b010, 3'd0, 3'd3, 2'd3, 1'b0};
    vecs[12] = '{3'b110, 3'd1, 3'd4, 2'd0, 1'b0};

    // Reset with next held high: no event when reset releases.
    next_r = 1'b1; bright_r = 1'b0; mode_r = 1'b0;
    do_reset(3);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_color",  bus8.color_o,  0);
      check("rst_bright", bus8.bright_o, 3);
      check("rst_mode",   bus8.mode_o,   0);
      check("rst_led",    bus8.led_o,    3'b111);
    end
    next_r = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) begin
      pulse(vecs[i].btn);
      check($sformatf("vec%0d_color8", i), bus8.color_o,  vecs[i].color8);
      check($sformatf("vec%0d_color5", i), bus5.color_o,  vecs[i].color5);
      check($sformatf("vec%0d_bright", i), bus8.bright_o, vecs[i].bright);
      check($sformatf("vec%0d_mode", i),   bus8.mode_o,   vecs[i].mode);
    end

    // Yellow at 25 %.
    repeat (3) pulse(3'b100);
    check("duty_color", bus8.color_o, 4);
    repeat (40) tick();
    measure(r_low, g_low, b_high);
    check("duty25_r", r_low, 4);
    check("duty25_g", g_low, 4);
    check("duty25_b", b_high, 16);

    repeat (3) pulse(3'b010);
    check("duty100_bright", bus8.bright_o, 3);
    repeat (40) tick();
    measure(r_low, g_low, b_high);
    check("duty100_r", r_low, 16);
    check("duty100_g", g_low, 16);
    check("duty100_b", b_high, 16);

    // Glitch-free: brightness 1 -> 2 pressed mid-period at cnt=5.
    repeat (2) pulse(3'b010);
    check("glitch_bright_start", bus8.bright_o, 1);
    repeat (40) tick();
    found = 1'b0;
    @(negedge clk);
    prev_r = bus8.led_o[2];
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (prev_r == 1'b1 && bus8.led_o[2] == 1'b0) found = 1'b1;
      else prev_r = bus8.led_o[2];
    end
    check("glitch_sync", found, 1);
    if (found) begin
      low0 = 0; low1 = 0;
      for (int k = 0; k < 32; k++) begin
        if (k > 0) @(negedge clk);
        if (bus8.led_o[2] == 1'b0) begin
          if (k < 16) low0++;
          else        low1++;
        end
        if (k == 4) bright_r = 1'b1;
        if (k == 6) bright_r = 1'b0;
      end
      check("glitch_cur_period",  low0, 8);
      check("glitch_next_period", low1, 12);
      check("glitch_bright_end",  bus8.bright_o, 2);
    end

    // Reset mid-period while lit.
    tick();
    do_reset(1);
    check("midrst_led",    bus8.led_o,    3'b111);
    check("midrst_color",  bus8.color_o,  0);
    check("midrst_bright", bus8.bright_o, 3);

    // AUTO: entering from colour 0 jumps to 1, then one step per 20 clocks, skipping 0.
    tick();
    mode_r = 1'b1;
    tick();
    mode_r = 1'b0;
    check("auto_enter_mode",  bus8.mode_o,  1);
    check("auto_enter_color", bus8.color_o, 1);
    exp_seq = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1};
    for (int i = 0; i < 7; i++) begin
      repeat (19) tick();
      check($sformatf("auto_hold%0d", i), bus8.color_o, (i == 0) ? 3'd1 : exp_seq[i-1]);
      tick();
      check($sformatf("auto_step%0d", i), bus8.color_o, exp_seq[i]);
    end

    // next together with hold expiry: one advance, next auto step 20 clocks later.
    repeat (19) tick();
    next_r = 1'b1;
    tick();
    next_r = 1'b0;
    check("merge_color", bus8.color_o, 2);
    repeat (19) tick();
    check("merge_hold", bus8.color_o, 2);
    tick();
    check("merge_auto", bus8.color_o, 3);

    // next mid-hold clears the hold counter.
    repeat (5) tick();
    next_r = 1'b1;
    tick();
    next_r = 1'b0;
    check("midnext_color", bus8.color_o, 4);
    repeat (19) tick();
    check("midnext_hold", bus8.color_o, 4);
    tick();
    check("midnext_auto", bus8.color_o, 5);

    // All three buttons rise together from reset.
    do_reset(2);
    tick();
    {next_r, bright_r, mode_r} = 3'b111;
    tick();
    {next_r, bright_r, mode_r} = 3'b000;
    check("simul_color8", bus8.color_o,  1);
    check("simul_color5", bus5.color_o,  1);
    check("simul_bright", bus8.bright_o, 0);
    check("simul_mode",   bus8.mode_o,   1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
